bg_pixel_fetch: RTL

- Downstream of the background region/address generator: consumes its per-pixel `bg_read_address` and `is_bg` region code.
- Issues the read to the background/scoreboard image memory and maps the returned 4-bit colour index through a per-region palette.
- Drives VGA RGB with sync/blank delayed to match the pipeline.
- Also owns the palette RAM, writable by the game logic via a valid/ready port that only accepts during vertical blank.

---
 rtl/bg_pkg.sv | 42 ++++
 rtl/bg_pixel_fetch_if.sv | 12 +
 rtl/bg_palette_ram.sv | 33 +++
 rtl/bg_pixel_fetch.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared types and constants for the background pixel fetch path.
package bg_pkg;

    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned REG_W       = 2;
    localparam int unsigned CH_W        = 8;
    localparam int unsigned OOB_W       = 8;
    localparam int unsigned PAL_ENTRIES = 48;
    localparam int unsigned PAL_AW      = 6;
    localparam int unsigned MAP_WORDS   = 153600;
    localparam int unsigned SCORE_WORDS = 76800;

    typedef enum logic [REG_W-1:0] {
        REG_NONE   = 2'd0,
        REG_MAP    = 2'd1,
        REG_SCORE1 = 2'd2,
        REG_SCORE2 = 2'd3
    } region_e;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb24_t;

    typedef enum logic [1:0] {
        PAL_CLEAR  = 2'd0,
        PAL_IDLE   = 2'd1,
        PAL_ACCEPT = 2'd2
    } pal_fsm_e;

    // Address lies beyond the image backing the given region.
    function automatic logic is_oob(input region_e r, input logic [ADDR_W-1:0] a);
        case (r)
            REG_MAP:                return a >= ADDR_W'(MAP_WORDS);
            REG_SCORE1, REG_SCORE2: return a >= ADDR_W'(SCORE_WORDS);
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bg_pixel_fetch_if.sv
// Palette write port: game logic (master) to pixel fetch block (slave).
interface bg_pixel_fetch_if;
    import bg_pkg::*;

    logic                pal_wr_valid;
    logic                pal_wr_ready;
    logic [PAL_AW-1:0]   pal_wr_idx;
    rgb24_t              pal_wr_rgb;

    modport master (output pal_wr_valid, output pal_wr_idx, output pal_wr_rgb, input  pal_wr_ready);
    modport slave  (input  pal_wr_valid, input  pal_wr_idx, input  pal_wr_rgb, output pal_wr_ready);
endinterface

// File: rtl/bg_palette_ram.sv
// 48x24 palette RAM: one write port, registered read-first port with a force-black option.
module bg_palette_ram
    import bg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [PAL_AW-1:0] rd_addr,
    output rgb24_t            rd_data,
    input  logic              wr_en,
    input  logic [PAL_AW-1:0] wr_addr,
    input  rgb24_t            wr_data
);

    rgb24_t mem [PAL_ENTRIES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read sees the pre-write contents on an address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/bg_pixel_fetch.sv
// Background pixel fetch: image memory read, per-region palette lookup, VGA output
// with timing delayed to match; owns the vblank-gated palette write port.
module bg_pixel_fetch
    import bg_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pixel_en,
    input  logic [ADDR_W-1:0] bg_read_address,
    input  logic [REG_W-1:0]  is_bg,
    input  logic              blank_n_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              vblank,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [REG_W-1:0]  mem_bank,
    input  logic [IDX_W-1:0]  mem_rdata,
    bg_pixel_fetch_if.slave   pal,
    output logic [CH_W-1:0]   VGA_R,
    output logic [CH_W-1:0]   VGA_G,
    output logic [CH_W-1:0]   VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic [OOB_W-1:0]  oob_count
);

    logic              in_oob;
    logic              s1_oob, s1_hs, s1_vs, s1_blank_n;
    logic [IDX_W-1:0]  s2_idx;
    region_e           s2_region;
    logic              s2_oob, s2_hs, s2_vs, s2_blank_n;
    logic              s3_zero;
    logic [REG_W-1:0]  s2_rsel;
    logic [PAL_AW-1:0] pal_rd_addr;
    rgb24_t            pal_rgb;
    logic              vs_prev;

    pal_fsm_e          state;
    logic [PAL_AW-1:0] clr_ptr;
    logic              wr_en;
    logic [PAL_AW-1:0] wr_addr;
    rgb24_t            wr_data;

    assign in_oob = is_oob(region_e'(is_bg), bg_read_address);

    // S1/S2 pipeline; out-of-bounds pixels fetch address 0 and are masked later.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            mem_addr   <= '0;
            mem_bank   <= '0;
            s1_oob     <= 1'b0;
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s1_blank_n <= 1'b0;
            s2_idx     <= '0;
            s2_region  <= REG_NONE;
            s2_oob     <= 1'b0;
            s2_hs      <= 1'b1;
            s2_vs      <= 1'b1;
            s2_blank_n <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else if (pixel_en) begin
            mem_addr   <= in_oob ? '0 : bg_read_address;
            mem_bank   <= is_bg;
            s1_oob     <= in_oob;
            s1_hs      <= hs_in;
            s1_vs      <= vs_in;
            s1_blank_n <= blank_n_in;
            s2_idx     <= mem_rdata;
            s2_region  <= region_e'(mem_bank);
            s2_oob     <= s1_oob;
            s2_hs      <= s1_hs;
            s2_vs      <= s1_vs;
            s2_blank_n <= s1_blank_n;
            VGA_HS      <= s2_hs;
            VGA_VS      <= s2_vs;
            VGA_BLANK_N <= s2_blank_n;
        end
    end

    // S3: palette lookup lands directly in the RAM output register.
    assign s3_zero     = !s2_blank_n || (s2_region == REG_NONE) || s2_oob;
    assign s2_rsel     = REG_W'(s2_region) - REG_W'(1);
    assign pal_rd_addr = {s2_rsel, s2_idx};

    bg_palette_ram u_palette (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .rd_en   (pixel_en),
        .rd_zero (s3_zero),
        .rd_addr (pal_rd_addr),
        .rd_data (pal_rgb),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    assign VGA_R = pal_rgb.r;
    assign VGA_G = pal_rgb.g;
    assign VGA_B = pal_rgb.b;

    // Per-frame out-of-bounds counter, cleared on vs_in falling edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vs_prev   <= 1'b1;
            oob_count <= '0;
        end else begin
            vs_prev <= vs_in;
            if (vs_prev && !vs_in) begin
                oob_count <= '0;
            end else if (pixel_en && in_oob && (oob_count != '1)) begin
                oob_count <= oob_count + OOB_W'(1);
            end
        end
    end

    // Palette ownership: clear all entries after reset, then accept writes only in vblank.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state   <= PAL_CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                PAL_CLEAR: begin
                    clr_ptr <= clr_ptr + PAL_AW'(1);
                    if (clr_ptr == PAL_AW'(PAL_ENTRIES - 1)) begin
                        state <= PAL_IDLE;
                    end
                end
                PAL_IDLE:   if (vblank)  state <= PAL_ACCEPT;
                PAL_ACCEPT: if (!vblank) state <= PAL_IDLE;
                default:    state <= PAL_CLEAR;
            endcase
        end
    end

    // Ready falls in the same cycle vblank does, so a late request simply waits.
    assign pal.pal_wr_ready = Reset_n && (state == PAL_ACCEPT) && vblank;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state == PAL_CLEAR) begin
            wr_en   = Reset_n;
            wr_addr = clr_ptr;
        end else if (pal.pal_wr_valid && pal.pal_wr_ready && (pal.pal_wr_idx[5:4] != 2'd3)) begin
            wr_en   = 1'b1;
            wr_addr = pal.pal_wr_idx;
            wr_data = pal.pal_wr_rgb;
        end
    end

endmodule
